mux_16x1: RTL and testbench

MUX_16X1 -- requirements
Module: mux_16x1

---
 rtl/mux_16x1.sv | 79 +++++++
 tb/tb_mux_16x1.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mux_16x1.sv
// Registered 16-to-1 single-bit multiplexer.
// The selection tree is two 8x1 stages joined by a 2x1 stage, and each 8x1
// stage is two 4x1 stages joined by a 2x1 stage. The selected bit is captured
// in a flop, so the output never depends combinationally on the inputs.
module mux_16x1 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_inputs,
    input  logic [3:0]  select_lines,
    output logic        mux_output
);

    // 2x1 leaf: returns in1 when sel is high, otherwise in0.
    function automatic logic mux_2x1(
        input logic in0,
        input logic in1,
        input logic sel
    );
        return sel ? in1 : in0;
    endfunction

    // 4x1 stage indexed by a 2-bit select. Every select value is covered,
    // so there is no fall-through case.
    function automatic logic mux_4x1(
        input logic [3:0] in,
        input logic [1:0] sel
    );
        logic result;
        case (sel)
            2'd0:    result = in[0];
            2'd1:    result = in[1];
            2'd2:    result = in[2];
            default: result = in[3];
        endcase
        return result;
    endfunction

    // 8x1 stage: two 4x1 stages on the low and high nibbles share sel[1:0],
    // and sel[2] picks between them.
    function automatic logic mux_8x1(
        input logic [7:0] in,
        input logic [2:0] sel
    );
        logic low_nibble_bit;
        logic high_nibble_bit;
        low_nibble_bit  = mux_4x1(in[3:0], sel[1:0]);
        high_nibble_bit = mux_4x1(in[7:4], sel[1:0]);
        return mux_2x1(low_nibble_bit, high_nibble_bit, sel[2]);
    endfunction

    logic low_half_bit;
    logic high_half_bit;
    logic sel_bit;
    logic mux_output_d;
    logic mux_output_q;

    // Build the selected bit from the two byte-wide stages.
    always_comb begin
        low_half_bit  = mux_8x1(data_inputs[7:0],  select_lines[2:0]);
        high_half_bit = mux_8x1(data_inputs[15:8], select_lines[2:0]);
        sel_bit       = mux_2x1(low_half_bit, high_half_bit, select_lines[3]);
    end

    // Next output value: reset forces 0 and overrides any pending selection.
    always_comb begin
        mux_output_d = sel_bit;
        if (rst) begin
            mux_output_d = 1'b0;
        end
    end

    // Output register, updated only on the rising clock edge.
    always_ff @(posedge clk) begin
        mux_output_q <= mux_output_d;
    end

    assign mux_output = mux_output_q;

endmodule

// File: tb/tb_mux_16x1.sv
// Self-checking bench for mux_16x1: directed vector table, walking-one sweep,
// reset and latency sequences, and randomized traffic against a reference model.
module tb_mux_16x1;

    logic        clk;
    logic        rst;
    logic [15:0] data_inputs;
    logic [3:0]  select_lines;
    logic        mux_output;

    int total;
    int bad;

    typedef struct {
        logic        rst_v;
        logic [15:0] data_v;
        logic [3:0]  sel_v;
        logic        exp_v;
    } vector_t;

    vector_t vectors[$];

    mux_16x1 dut (
        .clk          (clk),
        .rst          (rst),
        .data_inputs  (data_inputs),
        .select_lines (select_lines),
        .mux_output   (mux_output)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the output one edge later is the addressed bit, or 0 in reset.
    function automatic logic refModel(
        input logic        r,
        input logic [15:0] d,
        input logic [3:0]  s
    );
        int idx;
        idx = int'(s);
        if (r) return 1'b0;
        return ((d >> idx) & 16'd1) != 16'd0;
    endfunction

    // Drive inputs on the falling edge, away from the sampling edge.
    task automatic applyStimulus(
        input logic        r,
        input logic [15:0] d,
        input logic [3:0]  s
    );
        @(negedge clk);
        rst          = r;
        data_inputs  = d;
        select_lines = s;
    endtask

    task automatic checkOutput(input string name, input logic expv);
        total++;
        if (mux_output !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%b expected=%b (t=%0t)", name, mux_output, expv, $time);
        end
    endtask

    // Let one rising edge pass, then sample just after it.
    task automatic stepAndCheck(input string name, input logic expv);
        @(posedge clk);
        #1;
        checkOutput(name, expv);
    endtask

    initial begin
        logic        prev_exp;
        logic [15:0] d;
        logic [3:0]  s;
        logic        r;

        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        data_inputs  = 16'h0000;
        select_lines = 4'h0;

        // Directed table: reset, basic selection and boundary indices.
        vectors.push_back('{1'b1, 16'hFFFF, 4'h5, 1'b0});
        vectors.push_back('{1'b1, 16'hFFFF, 4'h5, 1'b0});
        vectors.push_back('{1'b0, 16'b1010101010101010, 4'b0000, 1'b0});
        vectors.push_back('{1'b0, 16'b1100110011001100, 4'b0001, 1'b0});
        vectors.push_back('{1'b0, 16'b1100110011001100, 4'b0010, 1'b1});
        vectors.push_back('{1'b0, 16'h8001, 4'd0,  1'b1});
        vectors.push_back('{1'b0, 16'h8001, 4'd7,  1'b0});
        vectors.push_back('{1'b0, 16'h8001, 4'd8,  1'b0});
        vectors.push_back('{1'b0, 16'h8001, 4'd15, 1'b1});
        vectors.push_back('{1'b0, 16'h0100, 4'd8,  1'b1});
        vectors.push_back('{1'b0, 16'h0080, 4'd7,  1'b1});

        $display("[TB] directed vectors");
        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i].rst_v, vectors[i].data_v, vectors[i].sel_v);
            stepAndCheck($sformatf("vec%0d", i), vectors[i].exp_v);
        end

        $display("[TB] walking one");
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                applyStimulus(1'b0, 16'(1 << i), 4'(j));
                stepAndCheck($sformatf("walk_d%0d_s%0d", i, j), (i == j));
            end
        end

        $display("[TB] mid-operation reset");
        applyStimulus(1'b0, 16'hFFFF, 4'd3);
        stepAndCheck("midrst_pre", 1'b1);
        applyStimulus(1'b1, 16'hFFFF, 4'd3);
        stepAndCheck("midrst_on", 1'b0);
        applyStimulus(1'b0, 16'hFFFF, 4'd3);
        stepAndCheck("midrst_recover", 1'b1);

        $display("[TB] latency toggle on bit 4");
        applyStimulus(1'b0, 16'h0000, 4'd4);
        stepAndCheck("lat_init", 1'b0);
        prev_exp = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            d = (k % 2 == 1) ? 16'h0010 : 16'h0000;
            applyStimulus(1'b0, d, 4'd4);
            #1;
            checkOutput($sformatf("lat_hold%0d", k), prev_exp);
            prev_exp = (k % 2 == 1);
            stepAndCheck($sformatf("lat_follow%0d", k), prev_exp);
        end

        $display("[TB] randomized traffic");
        for (int k = 0; k < 300; k++) begin
            d = 16'($urandom);
            s = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 15) == 0);
            applyStimulus(r, d, s);
            stepAndCheck($sformatf("rand%0d", k), refModel(r, d, s));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
